// File: rtl/serial_2_parallel_if.sv
// serial_2_parallel_if: framed serial input plus assembled-word output bundle
// for the serial_2_parallel deserializer. The master modport is the upstream
// serial source / downstream consumer side; the slave modport is the
// deserializer itself.
interface serial_2_parallel_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             spi_cs_n;
  logic             Filter_Input;
  logic [WIDTH-1:0] Filter_Input_Data;
  logic             data_valid;
  logic             frame_err;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output spi_cs_n,
    output Filter_Input,
    input  Filter_Input_Data,
    input  data_valid,
    input  frame_err,
    input  word_cnt
  );

  modport slave (
    input  spi_cs_n,
    input  Filter_Input,
    output Filter_Input_Data,
    output data_valid,
    output frame_err,
    output word_cnt
  );
endinterface

// File: rtl/serial_2_parallel.sv
// serial_2_parallel: MSB-first serial-to-parallel deserializer in the spi_sck
// domain. Words of WIDTH bits are assembled while spi_cs_n is low; each
// completed word is loaded into Filter_Input_Data with a one-cycle data_valid
// strobe, and words follow back-to-back while spi_cs_n stays low.
// Optional feature macro: S2P_FRAME_ERR_EN -- when defined, frame_err pulses
// for one cycle when a frame ends on a partial word; otherwise frame_err is 0.
module serial_2_parallel #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                 spi_sck,
  input  logic                 rst_n,
  serial_2_parallel_if.slave   bus
);

  localparam int BCW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             err_q,     err_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Bit position of the current sample; a frame always starts at bit 0.
  logic [BCW-1:0]   bit_idx;

  // State and datapath registers, all cleared asynchronously by rst_n.
  always_ff @(posedge spi_sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state: shift while selected, complete a word on its last bit,
  // clear the bit counter and flag a partial word when the frame ends.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    bit_idx   = (state_q == IDLE) ? '0 : bit_cnt_q;

    if (!bus.spi_cs_n) begin
      state_d = SHIFT;
      shift_d = {shift_q[WIDTH-2:0], bus.Filter_Input};
      if (bit_idx == LAST_BIT) begin
        bit_cnt_d = '0;
        data_d    = {shift_q[WIDTH-2:0], bus.Filter_Input};
        valid_d   = 1'b1;
        cnt_d     = cnt_q + 1'b1;
      end else begin
        bit_cnt_d = bit_idx + 1'b1;
      end
    end else begin
      state_d   = IDLE;
      bit_cnt_d = '0;
`ifdef S2P_FRAME_ERR_EN
      err_d     = (bit_idx != '0);
`else
      err_d     = 1'b0;
`endif
    end
  end

  assign bus.Filter_Input_Data = data_q;
  assign bus.data_valid        = valid_q;
  assign bus.frame_err         = err_q;
  assign bus.word_cnt          = cnt_q;

endmodule

// File: tb/tb_serial_2_parallel.sv
// tb_serial_2_parallel: randomized scenario bench for serial_2_parallel with a
// word-level reference model (expected words, counts and error pulses are
// derived from the list of words and tail bits sent in each frame).
module tb_serial_2_parallel;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
`ifdef S2P_FRAME_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  serial_2_parallel_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  serial_2_parallel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .spi_sck (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [WIDTH-1:0] exp_data;
  int               exp_cnt;
  logic [WIDTH-1:0] frame_words[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  // Drive one edge: inputs change on the falling edge, outputs observed 1 time unit after rising edge.
  task automatic clk_bit(input logic cs, input logic b);
    @(negedge clk);
    bus.spi_cs_n     = cs;
    bus.Filter_Input = b;
    @(posedge clk);
    #1;
  endtask

  // Send the queued words then tail_bits bits of tail_val (MSB first); optionally end the frame with one cs_n-high edge.
  task automatic run_frame(input string tag, input int tail_bits, input logic [WIDTH-1:0] tail_val,
                           input bit end_frame);
    int nw;
    logic [WIDTH-1:0] w;
    logic exp_v;
    nw = frame_words.size();
    for (int k = 0; k < nw * WIDTH + tail_bits; k++) begin
      if (k < nw * WIDTH) begin
        w = frame_words[k / WIDTH];
        clk_bit(1'b0, w[WIDTH - 1 - (k % WIDTH)]);
        exp_v = ((k % WIDTH) == WIDTH - 1);
        if (exp_v) begin
          exp_data = w;
          exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
        end
      end else begin
        clk_bit(1'b0, tail_val[tail_bits - 1 - (k - nw * WIDTH)]);
        exp_v = 1'b0;
      end
      n_total++;
      if (bus.data_valid !== exp_v)
        $display("FAIL %s valid bit%0d: got %b want %b", tag, k, bus.data_valid, exp_v);
      else n_pass++;
      n_total++;
      if (bus.Filter_Input_Data !== exp_data)
        $display("FAIL %s data bit%0d: got %h want %h", tag, k, bus.Filter_Input_Data, exp_data);
      else n_pass++;
      n_total++;
      if (bus.word_cnt !== CNT_W'(exp_cnt))
        $display("FAIL %s word_cnt bit%0d: got %0d want %0d", tag, k, bus.word_cnt, exp_cnt);
      else n_pass++;
      n_total++;
      if (bus.frame_err !== 1'b0)
        $display("FAIL %s frame_err bit%0d: got %b want 0", tag, k, bus.frame_err);
      else n_pass++;
    end
    if (end_frame) begin
      clk_bit(1'b1, 1'($urandom_range(0, 1)));
      n_total++;
      if (bus.frame_err !== (ERR_EN && tail_bits != 0))
        $display("FAIL %s end frame_err: got %b want %b", tag, bus.frame_err, ERR_EN && tail_bits != 0);
      else n_pass++;
      n_total++;
      if (bus.data_valid !== 1'b0)
        $display("FAIL %s end valid: got %b want 0", tag, bus.data_valid);
      else n_pass++;
      n_total++;
      if (bus.Filter_Input_Data !== exp_data)
        $display("FAIL %s end data: got %h want %h", tag, bus.Filter_Input_Data, exp_data);
      else n_pass++;
      n_total++;
      if (bus.word_cnt !== CNT_W'(exp_cnt))
        $display("FAIL %s end word_cnt: got %0d want %0d", tag, bus.word_cnt, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.spi_cs_n     = 1'b1;
    bus.Filter_Input = 1'b0;
    exp_data         = '0;
    exp_cnt          = 0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bus.Filter_Input_Data !== '0) $display("FAIL reset data: got %h want 0", bus.Filter_Input_Data);
    else n_pass++;
    n_total++;
    if (bus.data_valid !== 1'b0) $display("FAIL reset valid: got %b want 0", bus.data_valid);
    else n_pass++;
    n_total++;
    if (bus.frame_err !== 1'b0) $display("FAIL reset frame_err: got %b want 0", bus.frame_err);
    else n_pass++;
    n_total++;
    if (bus.word_cnt !== '0) $display("FAIL reset word_cnt: got %0d want 0", bus.word_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    clk_bit(1'b1, 1'b0);
  endtask

  task automatic test_single_frame();
    frame_words = '{16'hA5C3};
    run_frame("single", 0, '0, 1'b1);
  endtask

  task automatic test_continuous();
    frame_words = '{16'h0001, 16'h8000, 16'hFFFF};
    run_frame("contin", 0, '0, 1'b1);
  endtask

  task automatic test_short_frame();
    frame_words = '{};
    run_frame("short9", 9, WIDTH'($urandom), 1'b1);
    frame_words = '{16'h1234};
    run_frame("after_short", 0, '0, 1'b1);
  endtask

  // Random frames separated by a single cs_n-high edge, with random word counts and partial tails.
  task automatic test_random_frames();
    int nw;
    int tb_bits;
    for (int f = 0; f < 20; f++) begin
      nw = $urandom_range(0, 3);
      tb_bits = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, WIDTH - 1);
      if (nw == 0 && tb_bits == 0) nw = 1;
      frame_words = '{};
      for (int i = 0; i < nw; i++) frame_words.push_back(WIDTH'($urandom));
      run_frame("rand", tb_bits, WIDTH'($urandom), 1'b1);
    end
  endtask

  task automatic test_reset_mid_frame();
    frame_words = '{};
    run_frame("pre_rst", 10, WIDTH'($urandom), 1'b0);
    #2;
    rst_n    = 1'b0;
    exp_data = '0;
    exp_cnt  = 0;
    #1;
    n_total++;
    if (bus.Filter_Input_Data !== '0) $display("FAIL async_rst data: got %h want 0", bus.Filter_Input_Data);
    else n_pass++;
    n_total++;
    if (bus.word_cnt !== '0) $display("FAIL async_rst word_cnt: got %0d want 0", bus.word_cnt);
    else n_pass++;
    n_total++;
    if (bus.data_valid !== 1'b0 || bus.frame_err !== 1'b0)
      $display("FAIL async_rst strobes: got v=%b e=%b want 0", bus.data_valid, bus.frame_err);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b0, 1'($urandom_range(0, 1)));
      n_total++;
      if (bus.data_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.word_cnt !== '0)
        $display("FAIL in_rst outputs: got v=%b e=%b cnt=%0d want 0", bus.data_valid, bus.frame_err, bus.word_cnt);
      else n_pass++;
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.spi_cs_n = 1'b1;
    frame_words  = '{16'h00FF};
    run_frame("post_rst", 0, '0, 1'b1);
  endtask

  task automatic test_back_to_back_wrap();
    frame_words = '{};
    for (int i = 0; i < 256; i++) frame_words.push_back(WIDTH'($urandom));
    run_frame("wrap", 0, '0, 1'b1);
    n_total++;
    if (bus.word_cnt !== '0) $display("FAIL wrap final word_cnt: got %0d want 0", bus.word_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_short_frame();
    test_random_frames();
    test_reset_mid_frame();
    test_reset();
    test_back_to_back_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_2_parallel.md
# serial_2_parallel

Input deserializer for the Kalman filter datapath, running in the `spi_sck` domain. It samples a framed, MSB-first serial stream and assembles 16-bit words. It presents each completed word with a one-cycle valid strobe to the filter core, which then feeds the output serializer. Chip-select framing, continuous back-to-back words and short-frame error reporting are supported.

## Interface
- `WIDTH`, 16: word width in bits; must be ≥2.
- `CNT_W`, 8: width of the received-word counter.

Ports:
- `spi_sck` input 1: serial clock; the only clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `spi_cs_n` input 1: frame select, active-low; synchronous to `spi_sck`.
- `Filter_Input` input 1: serial data, MSB first; sampled on rising edge while `spi_cs_n`=0.
- `Filter_Input_Data` output WIDTH: last completed word; holds until the next completed word.
- `data_valid` output 1: one-cycle pulse; a new word was just loaded into `Filter_Input_Data`.
- `frame_err` output 1: one-cycle pulse; a frame ended with a partial word.
- `word_cnt` output CNT_W: count of completed words; wraps modulo 2^CNT_W.

## Operation
- State machine with two states:
  - IDLE: entered on reset, or when `spi_cs_n`=1 is sampled.
  - SHIFT: entered when `spi_cs_n`=0 is sampled.
- Each rising edge with `spi_cs_n`=0:
  - `shift_reg` <= {`shift_reg`[WIDTH-2:0], `Filter_Input`}.
  - `bit_cnt` <= `bit_cnt`+1.
- When the edge samples bit WIDTH-1 (`bit_cnt`==WIDTH-1), on that same edge:
  - `Filter_Input_Data` <= {`shift_reg`[WIDTH-2:0], `Filter_Input`}.
  - `data_valid` <= 1.
  - `word_cnt` increments.
  - `bit_cnt` wraps to 0.
- Continuous mode: if `spi_cs_n` stays low, the next edge begins the next word with no gap. This matches a downstream stage that reloads every 16 clocks.
- Edge with `spi_cs_n`=1:
  - `bit_cnt` <= 0; `shift_reg` is left unchanged (don't-care).
  - If `bit_cnt` was nonzero, the partial word is discarded; `frame_err` pulses when enabled (see Configuration).
- `data_valid` and `frame_err` are registered and default to 0 on every edge unless set as above.
- A partial word never updates `Filter_Input_Data`, `data_valid` or `word_cnt`.

## Timing
- Reset values:
  - `Filter_Input_Data`=0, `data_valid`=0, `frame_err`=0, `word_cnt`=0.
  - `bit_cnt`=0, `shift_reg`=0, state IDLE.
- Latency: `data_valid` and the new `Filter_Input_Data` become visible immediately after the edge that samples the LSB (bit WIDTH-1). The consumer samples them on the following edge.
- Throughput: one word per WIDTH clocks in continuous mode.
- `data_valid` is high for exactly one cycle per word. `Filter_Input_Data` is stable for at least WIDTH-1 cycles after it.
- Boundary conditions:
  - `spi_cs_n` rising on the edge after an LSB: no error, `bit_cnt` already 0.
  - `spi_cs_n` high for exactly one edge between frames: counter cleared, next frame starts clean.
  - `word_cnt` at 2^CNT_W-1 plus a completed word: wraps to 0, with `data_valid` still pulsing.
  - `rst_n` asserted mid-frame: all state cleared immediately (async). No `data_valid` or `frame_err` for the aborted word.
  - Deassertion of `rst_n` is expected synchronous to `spi_sck` upstream. The first edge after release is treated as bit 0 if `spi_cs_n`=0.

## Configuration
- Macro `S2P_FRAME_ERR_EN`:
  - Defined: short-frame detection is compiled in, and `frame_err` pulses one cycle when `spi_cs_n`=1 is sampled with `bit_cnt`≠0.
  - Undefined: detection logic is omitted and `frame_err` is tied to 0. Partial words are still discarded silently.

## Test plan
- Reset, then one frame of 16 bits 0xA5C3 with `spi_cs_n` low → single `data_valid` pulse, `Filter_Input_Data`=0xA5C3, `word_cnt`=1.
- `spi_cs_n` held low for 48 clocks, words 0x0001, 0x8000, 0xFFFF → `data_valid` pulses every 16 cycles with those values in order, `word_cnt`=3, `frame_err` never set.
- Frame of 9 bits then `spi_cs_n` high, followed by a full frame 0x1234:
  - `Filter_Input_Data` keeps its prior value after the short frame.
  - `frame_err` pulses once with `S2P_FRAME_ERR_EN` defined (stays 0 when undefined).
  - The following frame yields 0x1234.
- `rst_n` pulsed low at bit 10 of a frame → outputs return to reset values asynchronously. After release, a full frame 0x00FF is received correctly with `word_cnt`=1.
- 256 back-to-back words with CNT_W=8 → `word_cnt` wraps to 0 on the 256th `data_valid`.
